// File: rtl/tpumac_skew_feeder_if.sv
// Row-input handshake bundle for the skew feeder: source drives a packed
// operand row plus last-row flag, feeder returns ready.
interface tpumac_skew_feeder_if #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DIM*BITS_AB-1:0] in_row;
    logic                   in_last;

    modport master (
        output in_valid,
        output in_row,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_row,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/tpumac_skew_feeder.sv
// Skew feeder for one edge of a DIM-wide tpumac systolic array. Each accepted
// row is launched diagonally (lane i delayed i cycles behind lane 0), and a
// one-cycle done pulse marks the moment the last diagonal has fully left.
module tpumac_skew_feeder #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tpumac_skew_feeder_if.slave    bus,
    output logic [DIM*BITS_AB-1:0] lane_out,
    output logic [DIM-1:0]         lane_vld,
    output logic                   en_out,
    output logic                   done
);

    localparam int unsigned CW = (DIM > 2) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready;
    logic          accept;

    // Ready depends on state only, so there is no path from in_valid to in_ready.
    assign ready        = (state_q == StIdle) || (state_q == StStream);
    assign bus.in_ready = ready;
    assign accept       = bus.in_valid && ready;

    // State and drain-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the drain counter covers the DIM-1 extra cycles the
    // last row needs to reach the far lane.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        unique case (state_q)
            StIdle, StStream: begin
                if (accept) begin
                    if (bus.in_last) begin
                        state_d = StDrain;
                        cnt_d   = CW'(DIM - 1);
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // One register chain per lane; lane i has i+1 stages.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic [i:0][BITS_AB-1:0] data_q;
        logic [i:0]              vld_q;

        // Shift the chain each cycle; non-accept cycles inject a zero bubble.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                vld_q  <= '0;
            end else begin
                data_q[0] <= accept ? bus.in_row[i*BITS_AB +: BITS_AB] : '0;
                vld_q[0]  <= accept;
                for (int j = 1; j <= i; j++) begin
                    data_q[j] <= data_q[j-1];
                    vld_q[j]  <= vld_q[j-1];
                end
            end
        end

        assign lane_vld[i]                      = vld_q[i];
        assign lane_out[i*BITS_AB +: BITS_AB]   = vld_q[i] ? data_q[i] : '0;
    end

    assign en_out = |lane_vld;

endmodule

// File: tb/tb_tpumac_skew_feeder.sv
// Directed bench for tpumac_skew_feeder with DIM=4, BITS_AB=8. Expected lane
// contents per cycle are hand-derived diagonals; lanes packed {l3,l2,l1,l0}.
module tb_tpumac_skew_feeder;

    localparam int unsigned BITS_AB = 8;
    localparam int unsigned DIM     = 4;

    logic                   clk;
    logic                   rst_n;
    logic [DIM*BITS_AB-1:0] lane_out;
    logic [DIM-1:0]         lane_vld;
    logic                   en_out;
    logic                   done;

    int n_checks = 0;
    int n_errors = 0;

    tpumac_skew_feeder_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

    tpumac_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .lane_out (lane_out),
        .lane_vld (lane_vld),
        .en_out   (en_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check every output for one cycle.
    task automatic cyc(string tag, logic [31:0] eo, logic [3:0] ev, logic een,
                       logic erdy, logic edone);
        chk({tag, ".lane_out"}, lane_out, eo);
        chk({tag, ".lane_vld"}, {28'd0, lane_vld}, {28'd0, ev});
        chk({tag, ".en_out"},   {31'd0, en_out}, {31'd0, een});
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, erdy});
        chk({tag, ".done"},     {31'd0, done}, {31'd0, edone});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] row, logic last);
        bus.in_valid = v;
        bus.in_row   = row;
        bus.in_last  = last;
    endtask

    // Four back-to-back rows {1..4},{5..8},{9..12},{13..16}, last flagged.
    task automatic run_basic(string tag);
        drive(1'b1, 32'h04030201, 1'b0); tick(); cyc({tag, ".t1"}, 32'h00000001, 4'b0001, 1, 1, 0);
        drive(1'b1, 32'h08070605, 1'b0); tick(); cyc({tag, ".t2"}, 32'h00000205, 4'b0011, 1, 1, 0);
        drive(1'b1, 32'h0c0b0a09, 1'b0); tick(); cyc({tag, ".t3"}, 32'h00030609, 4'b0111, 1, 1, 0);
        drive(1'b1, 32'h100f0e0d, 1'b1); tick(); cyc({tag, ".t4"}, 32'h04070a0d, 4'b1111, 1, 0, 0);
        drive(1'b0, 32'h0, 1'b0);        tick(); cyc({tag, ".t5"}, 32'h080b0e00, 4'b1110, 1, 0, 0);
        tick(); cyc({tag, ".t6"}, 32'h0c0f0000, 4'b1100, 1, 0, 0);
        tick(); cyc({tag, ".t7"}, 32'h10000000, 4'b1000, 1, 0, 0);
        tick(); cyc({tag, ".t8"}, 32'h00000000, 4'b0000, 0, 0, 1);
        tick(); cyc({tag, ".t9"}, 32'h00000000, 4'b0000, 0, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #12;
        cyc("in_reset", 32'h0, 4'b0000, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int k = 0; k < 5; k++) begin
            tick();
            cyc("idle", 32'h0, 4'b0000, 0, 1, 0);
        end

        run_basic("basic");

        // Gap after row 2; garbage on in_row while invalid must not leak.
        drive(1'b1, 32'h04030201, 1'b0); tick(); cyc("gap.t1", 32'h00000001, 4'b0001, 1, 1, 0);
        drive(1'b1, 32'h08070605, 1'b0); tick(); cyc("gap.t2", 32'h00000205, 4'b0011, 1, 1, 0);
        drive(1'b0, 32'hffffffff, 1'b1); tick(); cyc("gap.t3", 32'h00030600, 4'b0110, 1, 1, 0);
        drive(1'b1, 32'h0c0b0a09, 1'b0); tick(); cyc("gap.t4", 32'h04070009, 4'b1101, 1, 1, 0);
        drive(1'b1, 32'h100f0e0d, 1'b1); tick(); cyc("gap.t5", 32'h08000a0d, 4'b1011, 1, 0, 0);
        drive(1'b0, 32'h0, 1'b0);        tick(); cyc("gap.t6", 32'h000b0e00, 4'b0110, 1, 0, 0);
        tick(); cyc("gap.t7", 32'h0c0f0000, 4'b1100, 1, 0, 0);
        tick(); cyc("gap.t8", 32'h10000000, 4'b1000, 1, 0, 0);
        tick(); cyc("gap.t9", 32'h00000000, 4'b0000, 0, 0, 1);
        tick(); cyc("gap.t10", 32'h00000000, 4'b0000, 0, 1, 0);

        // Single-row matrix of {-128,-1,127,0}, then {9,9,9,9} held valid
        // throughout the drain; it may only be taken once, back in idle.
        drive(1'b1, 32'h007fff80, 1'b1); tick(); cyc("neg.t1", 32'h00000080, 4'b0001, 1, 0, 0);
        drive(1'b1, 32'h09090909, 1'b1); tick(); cyc("neg.t2", 32'h0000ff00, 4'b0010, 1, 0, 0);
        tick(); cyc("neg.t3", 32'h007f0000, 4'b0100, 1, 0, 0);
        tick(); cyc("neg.t4", 32'h00000000, 4'b1000, 1, 0, 0);
        tick(); cyc("neg.t5", 32'h00000000, 4'b0000, 0, 0, 1);
        tick(); cyc("hold.idle", 32'h00000000, 4'b0000, 0, 1, 0);
        tick(); drive(1'b0, 32'h0, 1'b0);
        cyc("hold.t1", 32'h00000009, 4'b0001, 1, 0, 0);
        tick(); cyc("hold.t2", 32'h00000900, 4'b0010, 1, 0, 0);
        tick(); cyc("hold.t3", 32'h00090000, 4'b0100, 1, 0, 0);
        tick(); cyc("hold.t4", 32'h09000000, 4'b1000, 1, 0, 0);
        tick(); cyc("hold.t5", 32'h00000000, 4'b0000, 0, 0, 1);
        tick(); cyc("hold.t6", 32'h00000000, 4'b0000, 0, 1, 0);

        // Reset asserted the cycle after row 2 of a 4-row matrix.
        drive(1'b1, 32'h04030201, 1'b0); tick();
        drive(1'b1, 32'h08070605, 1'b0); tick();
        cyc("pre_rst", 32'h00000205, 4'b0011, 1, 1, 0);
        drive(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        cyc("mid_rst", 32'h0, 4'b0000, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            cyc("post_rst", 32'h0, 4'b0000, 0, 1, 0);
        end

        run_basic("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tpumac_skew_feeder.md
Name: tpumac_skew_feeder

Overview:
- Drives the A (or B) edge of a DIM-wide systolic array of tpumac cells.
- Accepts one full operand row per handshake and emits a diagonally skewed stream: lane i is delayed i cycles relative to lane 0.
- Each cell in the array therefore sees matching A/B operands on the same cycle.
- Also generates the array enable (en_out) and an end-of-matrix done pulse once the last skewed element has left the feeder.

Parameters:
- BITS_AB, 8, signed operand width per lane (matches tpumac BITS_AB).
- DIM, 8, number of lanes (array rows/columns); must be ≥ 2.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_row/in_last are valid this cycle.
- in_ready  out  1  feeder can accept a row this cycle.
- in_row  in  DIM*BITS_AB  packed row; lane i = bits [i*BITS_AB +: BITS_AB], signed.
- in_last  in  1  accompanying row is the final row of the matrix.
- lane_out  out  DIM*BITS_AB  packed skewed operands to array edge, same lane packing.
- lane_vld  out  DIM  per-lane valid; lane_out lane i is zero whenever lane_vld[i]=0.
- en_out  out  1  array enable, equal to OR of lane_vld.
- done  out  1  one-cycle pulse, matrix fully drained.

Behaviour:
- Handshake:
  - A row is accepted on a posedge where in_valid && in_ready.
  - in_ready is combinational from state only: 1 in IDLE and STREAM, 0 in DRAIN and DONE.
  - The source may hold in_valid high with ready low; no data is lost or duplicated.
- Skew pipeline:
  - Lane i is a chain of i+1 registers (data + valid bit).
  - A row accepted at edge t appears on lane 0 outputs after edge t, and on lane i after edge t+i. The latency for lane i is therefore i+1 cycles from in_valid sampling to output.
- Bubbles:
  - Any cycle with no acceptance shifts a zero data word with valid=0 into the lane-0 stage of every chain. Bubbles propagate diagonally like data.
  - lane_out lanes are forced to 0 when invalid. The array accumulates +0, which is harmless.
- en_out = |lane_vld, combinational from registered valid bits. No extra latency.
- FSM:
  - IDLE: in_ready=1. Acceptance with in_last=0 -> STREAM. Acceptance with in_last=1 -> DRAIN. No acceptance -> stay.
  - STREAM: in_ready=1. Acceptance with in_last=1 -> DRAIN. Otherwise stay; gaps are allowed.
  - DRAIN:
    - in_ready=0 and bubbles only.
    - A drain counter loads DIM-1 on entry and decrements each cycle.
    - At counter==0, when the last row's lane DIM-1 word is on the outputs, go to DONE.
  - DONE:
    - done=1 for exactly one cycle, in_ready=0, and all lane_vld are already 0.
    - Next state is IDLE.
- Consecutive matrices: a new row may be accepted the cycle after DONE (in IDLE). The minimum gap between the last row of one matrix and the first row of the next is DIM+1 cycles.
- Single-row matrix (IDLE acceptance with in_last=1) is legal and produces one diagonal plus done.
- Reset:
  - Values while rst_n=0: lane_out=0, lane_vld=0, en_out=0, done=0, state=IDLE, drain counter=0. in_ready=1 (IDLE).
  - Assertion mid-stream or mid-drain discards all in-flight data immediately, with no done pulse.
- Values are passed unmodified, with no sign extension or arithmetic. Widths are preserved per lane.

Test Plan:
- DIM=4, reset then idle 5 cycles -> lane_vld=0, en_out=0, done=0, in_ready=1 throughout.
- Four back-to-back rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, the last with in_last -> lane 0 shows 1,5,9,13 on cycles t+1..t+4. Lane 3 shows 4,8,12,16 on t+4..t+7. en_out is high t+1..t+7. done pulses at t+8. in_ready is low from t+4 until done.
- Same rows with a one-cycle in_valid gap after row 2 -> zero/invalid bubble appears diagonally, lane 2 shows 3,7,0(vld=0),11,15, and done is delayed by one cycle.
- Negative operands (-128, -1, 127, 0) with BITS_AB=8 -> identical bit patterns emerged per lane, no sign corruption.
- in_valid held high during DRAIN with a new row {9,9,9,9} -> not accepted until IDLE. It then emerges once on lane 0, with no duplication.
- rst_n pulsed low at the cycle after the 2nd row of a 4-row matrix -> all outputs 0 asynchronously, no done, and a fresh matrix afterwards behaves as in scenario 2.
